cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Instruction register plus control FSM that drives the datapath control interface
//  (writenum/write/readnum/loada/loadb/shift/asel/bsel/ALUop/loadc/loads/vsel).
//  It decodes one 16-bit instruction per s pulse into a cycle-by-cycle control sequence.
//  It raises w when idle. This is the initiator side of the datapath control interface.
// PARAMETERS
//  (none; instruction width fixed at 16, register index 3, datapath word 16)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in         in   16  instruction word
//  load       in   1   latch in -> IR (accepted only while w=1)
//  s          in   1   start execution of IR (sampled only in S_WAIT)
//  w          out  1   1 = idle in S_WAIT
//  readnum    out  3   register-file read index
//  writenum   out  3   register-file write index
//  write      out  1   register-file write enable
//  loada      out  1   A register load
//  loadb      out  1   B register load
//  loadc      out  1   C register load
//  loads      out  1   status register load
//  asel       out  1   1 = ALU A input forced to 0
//  bsel       out  1   1 = ALU B input = sximm5 (always 0 for this ISA subset)
//  shift      out  2   shifter op on B
//  ALUop      out  2   00 add, 01 sub, 10 and, 11 not-B
//  vsel       out  2   writeback source: 00 mdata, 01 sximm8, 10 {8'b0,PC}, 11 C
//  sximm8     out  16  sign-extended IR[7:0]
//  sximm5     out  16  sign-extended IR[4:0]
//  illegal    out  1   sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - IR format: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
//  - Reset (async, immediate on reset_n=0): state=S_WAIT, IR=0, illegal=0, w=1.
//    All other outputs are 0 during reset, including write=0 mid-sequence.
//  - Outputs are Moore: decoded combinationally from the registered state and IR only.
//    Outputs not listed for a state are 0.
//  - load is ignored unless state=S_WAIT.
//    load and s in the same S_WAIT cycle: IR takes the new in, and DECODE uses the new IR.
//  - Transitions:
//    S_WAIT -s-> S_DECODE.
//    S_DECODE branches on {opcode,op}:
//      110_10 MOV Rn,#imm8 : -> S_WB_IMM -> S_WAIT
//      110_00 MOV Rd,Rm,sh : -> S_LOAD_B -> S_ALU -> S_WB -> S_WAIT
//      101_00 ADD / 101_10 AND : -> S_LOAD_A -> S_LOAD_B -> S_ALU -> S_WB -> S_WAIT
//      101_01 CMP          : -> S_LOAD_A -> S_LOAD_B -> S_ALU -> S_WAIT
//      101_11 MVN Rd,Rm,sh : -> S_LOAD_B -> S_ALU -> S_WB -> S_WAIT
//      other               : illegal (see CONFIGURATION)
//  - Busy cycles (state != S_WAIT): MOV#=2, MOV=4, ADD/AND=5, CMP=4, MVN=4.
//  - Per-state outputs:
//    S_WB_IMM : write=1, writenum=Rn, vsel=01
//    S_LOAD_A : loada=1, readnum=Rn
//    S_LOAD_B : loadb=1, readnum=Rm
//    S_ALU    : loadc=1 except CMP; loads=1 only CMP; asel=1 only MOV reg
//    S_WB     : write=1, writenum=Rd, vsel=11
//  - shift=IR[4:3] in S_LOAD_B/S_ALU/S_WB for reg-form instrs, else 00.
//    ALUop: MOV reg=00, MVN=11, other 101 instrs=IR[12:11].
//  - sximm8/sximm5 track IR continuously. No state waits on datapath status.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:
//    illegal opcode in S_DECODE -> S_HALT, illegal=1, w=0.
//    S_HALT is held until reset; load and s are ignored there.
//  CTRL_ILLEGAL_TRAP_EN undefined:
//    illegal opcode treated as NOP (S_DECODE -> S_WAIT, 1 busy cycle).
//    illegal tied 0 and no S_HALT state exists.
// TESTING
//  T1 reset_n=0 mid-ADD (during S_WB) -> same cycle w=1, write=0, all controls 0; IR=0 after release.
//  T2 in=16'hD005 (MOV R0,#5), load+s -> 2 busy cycles; S_WB_IMM has write=1, writenum=0,
//     vsel=01, sximm8=16'h0005; w=1 on 3rd cycle.
//  T3 in=16'hA049 (ADD R2,R0,R1,LSL#1) -> loada rn0; loadb rn1 sh01; loadc ALUop00;
//     write wn2 vsel11; w after 5 busy cycles.
//  T4 in=16'hA801 (CMP R0,R1) -> S_ALU has loads=1, loadc=0; write never asserts; 4 busy cycles.
//  T5 in=16'hB861 (MVN R3,R1) -> no loada; ALUop=11, writenum=3; in=16'hFF80 gives sximm8=16'hFF80.
//     load during busy is ignored (IR unchanged).
//  T6 in=16'hE000 -> with macro: w=0, illegal=1, stuck until reset.
//     Without macro: 1 busy cycle then w=1, illegal=0.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller
//   Instruction register plus control FSM driving the datapath control
//   interface. One 16-bit instruction is latched into IR and expanded into a
//   cycle-by-cycle control sequence per s pulse; w is high while idle.
//   All control outputs are Moore outputs decoded from the registered state
//   and IR, so they drop to their idle values as soon as reset_n goes low.
//
//   Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//     defined   : an unknown opcode parks the FSM in S_HALT (illegal=1, w=0)
//                 until reset.
//     undefined : an unknown opcode is a one-cycle NOP; illegal is tied 0.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low reset
//   in        in   16  instruction word
//   load      in   1   latch in into IR (only in S_WAIT)
//   s         in   1   start execution of IR (only in S_WAIT)
//   w         out  1   idle in S_WAIT
//   readnum   out  3   register-file read index
//   writenum  out  3   register-file write index
//   write     out  1   register-file write enable
//   loada     out  1   A register load
//   loadb     out  1   B register load
//   loadc     out  1   C register load
//   loads     out  1   status register load
//   asel      out  1   ALU A input forced to 0
//   bsel      out  1   ALU B input = sximm5 (unused by this ISA subset)
//   shift     out  2   shifter op on B
//   ALUop     out  2   00 add, 01 sub, 10 and, 11 not-B
//   vsel      out  2   writeback source: 00 mdata, 01 sximm8, 10 PC, 11 C
//   sximm8    out  16  sign-extended IR[7:0]
//   sximm5    out  16  sign-extended IR[4:0]
//   illegal   out  1   sticky illegal-opcode flag
module cpu_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WB_IMM,
    S_LOAD_A,
    S_LOAD_B,
    S_ALU,
    S_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t      state;
  logic [15:0] ir;

  // IR fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OP_MOV_REG = 5'b110_00;
  localparam logic [4:0] OP_ADD     = 5'b101_00;
  localparam logic [4:0] OP_CMP     = 5'b101_01;
  localparam logic [4:0] OP_AND     = 5'b101_10;
  localparam logic [4:0] OP_MVN     = 5'b101_11;

  logic [4:0] opc;
  logic       is_mov_reg;
  logic       is_mvn;
  logic       is_cmp;

  assign opc        = {opcode, op};
  assign is_mov_reg = (opc == OP_MOV_REG);
  assign is_mvn     = (opc == OP_MVN);
  assign is_cmp     = (opc == OP_CMP);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // State and IR. load and s in the same S_WAIT cycle both take effect, so
  // S_DECODE sees the freshly loaded instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          if (load) ir <= in;
          if (s) state <= S_DECODE;
        end
        S_DECODE: begin
          case (opc)
            OP_MOV_IMM:                 state <= S_WB_IMM;
            OP_MOV_REG, OP_MVN:         state <= S_LOAD_B;
            OP_ADD, OP_AND, OP_CMP:     state <= S_LOAD_A;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state     <= S_HALT;
              illegal_q <= 1'b1;
`else
              state <= S_WAIT;
`endif
            end
          endcase
        end
        S_WB_IMM: state <= S_WAIT;
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= S_ALU;
        S_ALU:    state <= is_cmp ? S_WAIT : S_WB;
        S_WB:     state <= S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT:   state <= S_HALT;
`endif
        default:  state <= S_WAIT;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    vsel     = '0;
    case (state)
      S_WAIT: w = 1'b1;
      S_WB_IMM: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = 2'b01;
      end
      S_LOAD_A: begin
        loada   = 1'b1;
        readnum = rn;
      end
      S_LOAD_B: begin
        loadb   = 1'b1;
        readnum = rm;
        shift   = sh;
      end
      S_ALU: begin
        loadc = !is_cmp;
        loads = is_cmp;
        asel  = is_mov_reg;
        shift = sh;
        if (is_mov_reg)  ALUop = 2'b00;
        else if (is_mvn) ALUop = 2'b11;
        else             ALUop = op;
      end
      S_WB: begin
        write    = 1'b1;
        writenum = rd;
        vsel     = 2'b11;
        shift    = sh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
//   Directed bench for cpu_controller: reset state, MOV#, ADD, CMP, MVN,
//   MOV reg, async reset mid-sequence, load-while-busy, illegal opcode.
module tb_cpu_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [1:0]  vsel;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        illegal;

  int unsigned tests;
  int unsigned fails;

  cpu_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .sximm5   (sximm5),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {write,loada,loadb,loadc,loads,asel,bsel,shift,ALUop,vsel,readnum,writenum}
  logic [18:0] ctl;
  assign ctl = {write, loada, loadb, loadc, loads, asel, bsel,
                shift, ALUop, vsel, readnum, writenum};

  function automatic logic [18:0] ec(input logic wr, input logic la,
                                     input logic lb, input logic lc,
                                     input logic ls, input logic as,
                                     input logic [1:0] sh, input logic [1:0] alu,
                                     input logic [1:0] vs, input logic [2:0] rn,
                                     input logic [2:0] wn);
    return {wr, la, lb, lc, ls, as, 1'b0, sh, alu, vs, rn, wn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load and start in one S_WAIT cycle; returns in S_DECODE.
  task automatic start(input logic [15:0] instr);
    in   = instr;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    in      = '0;
    load    = 1'b0;
    s       = 1'b0;

    // Reset state
    #2;
    chk("rst_w", 32'(w), 32'd1);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_sximm8", 32'(sximm8), 32'h0);
    #1 reset_n = 1'b1;
    step();
    chk("idle_w", 32'(w), 32'd1);

    // T2: MOV R0,#5
    start(16'hD005);
    chk("mov_imm_dec_w", 32'(w), 32'd0);
    chk("mov_imm_dec_ctl", 32'(ctl), 32'd0);
    step();
    chk("mov_imm_wb_ctl", 32'(ctl), 32'(ec(1,0,0,0,0,0,2'b00,2'b00,2'b01,3'd0,3'd0)));
    chk("mov_imm_sximm8", 32'(sximm8), 32'h0005);
    chk("mov_imm_wb_w", 32'(w), 32'd0);
    step();
    chk("mov_imm_done_w", 32'(w), 32'd1);

    // T3: ADD R2,R0,R1,LSL#1
    start(16'hA049);
    chk("add_dec_ctl", 32'(ctl), 32'd0);
    chk("add_sximm5", 32'(sximm5), 32'h0009);
    step();
    chk("add_la_ctl", 32'(ctl), 32'(ec(0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0)));
    step();
    chk("add_lb_ctl", 32'(ctl), 32'(ec(0,0,1,0,0,0,2'b01,2'b00,2'b00,3'd1,3'd0)));
    step();
    chk("add_alu_ctl", 32'(ctl), 32'(ec(0,0,0,1,0,0,2'b01,2'b00,2'b00,3'd0,3'd0)));
    step();
    chk("add_wb_ctl", 32'(ctl), 32'(ec(1,0,0,0,0,0,2'b01,2'b00,2'b11,3'd0,3'd2)));
    chk("add_wb_w", 32'(w), 32'd0);
    step();
    chk("add_done_w", 32'(w), 32'd1);

    // T4: CMP R0,R1
    start(16'hA801);
    step();
    chk("cmp_la_ctl", 32'(ctl), 32'(ec(0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0)));
    step();
    chk("cmp_lb_ctl", 32'(ctl), 32'(ec(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0)));
    step();
    chk("cmp_alu_ctl", 32'(ctl), 32'(ec(0,0,0,0,1,0,2'b00,2'b01,2'b00,3'd0,3'd0)));
    step();
    chk("cmp_done_w", 32'(w), 32'd1);
    chk("cmp_done_write", 32'(write), 32'd0);

    // T5: sign extension of a loaded word, then MVN R3,R1 with load while busy
    in   = 16'hFF80;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("ld_w", 32'(w), 32'd1);
    chk("ld_sximm8", 32'(sximm8), 32'hFF80);
    chk("ld_sximm5", 32'(sximm5), 32'h0000);
    start(16'hB861);
    chk("mvn_dec_w", 32'(w), 32'd0);
    in   = 16'hFF80;
    load = 1'b1;
    step();
    chk("mvn_lb_ctl", 32'(ctl), 32'(ec(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0)));
    step();
    chk("mvn_alu_ctl", 32'(ctl), 32'(ec(0,0,0,1,0,0,2'b00,2'b11,2'b00,3'd0,3'd0)));
    step();
    chk("mvn_wb_ctl", 32'(ctl), 32'(ec(1,0,0,0,0,0,2'b00,2'b00,2'b11,3'd0,3'd3)));
    load = 1'b0;
    step();
    chk("mvn_done_w", 32'(w), 32'd1);
    chk("busy_load_ignored", 32'(sximm8), 32'h0061);

    // MOV R2,R2,ASR: reg-form move uses asel
    start(16'hC05A);
    step();
    chk("movr_lb_ctl", 32'(ctl), 32'(ec(0,0,1,0,0,0,2'b11,2'b00,2'b00,3'd2,3'd0)));
    step();
    chk("movr_alu_ctl", 32'(ctl), 32'(ec(0,0,0,1,0,1,2'b11,2'b00,2'b00,3'd0,3'd0)));
    step();
    chk("movr_wb_ctl", 32'(ctl), 32'(ec(1,0,0,0,0,0,2'b11,2'b00,2'b11,3'd0,3'd2)));
    step();
    chk("movr_done_w", 32'(w), 32'd1);

    // T1: async reset during S_WB of an ADD
    start(16'hA049);
    step();
    step();
    step();
    step();
    chk("t1_pre_write", 32'(write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t1_rst_w", 32'(w), 32'd1);
    chk("t1_rst_ctl", 32'(ctl), 32'd0);
    #1 reset_n = 1'b1;
    chk("t1_ir_sximm8", 32'(sximm8), 32'h0000);
    chk("t1_ir_sximm5", 32'(sximm5), 32'h0000);
    step();
    chk("t1_idle_w", 32'(w), 32'd1);

    // T6: illegal opcode
    start(16'hE000);
    chk("ill_dec_w", 32'(w), 32'd0);
    step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_halt_w", 32'(w), 32'd0);
    chk("ill_halt_flag", 32'(illegal), 32'd1);
    in   = 16'hD005;
    load = 1'b1;
    s    = 1'b1;
    step();
    step();
    step();
    chk("ill_stuck_w", 32'(w), 32'd0);
    chk("ill_stuck_flag", 32'(illegal), 32'd1);
    chk("ill_stuck_ctl", 32'(ctl), 32'd0);
    chk("ill_stuck_ir", 32'(sximm8), 32'h0000);
    load = 1'b0;
    s    = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("ill_rst_flag", 32'(illegal), 32'd0);
    chk("ill_rst_w", 32'(w), 32'd1);
    #1 reset_n = 1'b1;
`else
    chk("ill_nop_w", 32'(w), 32'd1);
    chk("ill_nop_flag", 32'(illegal), 32'd0);
    step();
    chk("ill_nop_flag2", 32'(illegal), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
